// File: rtl/mux_scan_n_pkg.sv
// Shared types and helpers for the N-to-1 scan multiplexer and its round-robin finder.
package mux_pkg;

   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   typedef enum logic [0:0] {
      ST_DIRECT = 1'b0,
      ST_SCAN   = 1'b1
   } state_e;

   // Bits needed to index v items; never less than 1 so a 1-entry range still has a port.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// Channel bus between the multi-channel sources/controller and the scan multiplexer.
interface mux_scan_n_if #(
   parameter int N = 8,
   parameter int W = 1
);
   localparam int SW = mux_pkg::clog2(N);

   logic [N*W-1:0] in_bus;
   logic [SW-1:0]  sel;
   logic           mode;
   logic           en;
   logic [N-1:0]   mask;
   logic [W-1:0]   out;
   logic [SW-1:0]  out_sel;
   logic           out_valid;

   // No back-pressure: out/out_sel are qualified by out_valid and held while en=0;
   // out_valid=0 marks an illegal select or a masked/empty scan slot (out is then 0 or stale channel data).
   modport master (
      output in_bus, sel, mode, en, mask,
      input  out, out_sel, out_valid
   );

   modport slave (
      input  in_bus, sel, mode, en, mask,
      output out, out_sel, out_valid
   );
endinterface

// File: rtl/mux_scan_n_rr_next.sv
// Combinational circular search for the next unmasked index after ptr (wraps N-1 -> 0).
module rr_next #(
   parameter int N  = 8,
   parameter int SW = mux_pkg::clog2(N)
) (
   input  logic [SW-1:0] ptr,
   input  logic [N-1:0]  mask,
   output logic [SW-1:0] next,
   output logic          any_unmasked
);

   int            j;
   logic [SW-1:0] idx;
   logic          found;

   // Offset N revisits ptr itself, so a lone unmasked channel keeps the pointer.
   always_comb begin
      next  = ptr;
      found = 1'b0;
      j     = 0;
      idx   = '0;
      for (int i = 1; i <= N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         idx = SW'(j);
         if (!found && !mask[idx]) begin
            next  = idx;
            found = 1'b1;
         end
      end
      any_unmasked = found;
   end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-to-1 multiplexer: direct select, or automatic scan of unmasked channels with a fixed dwell.
module mux_scan_n
   import mux_pkg::*;
#(
   parameter int N     = 8,
   parameter int W     = 1,
   parameter int DWELL = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   mux_scan_n_if.slave  bus,
   output state_e       dbg_state
);

   localparam int SW = clog2(N);
   localparam int CW = clog2(DWELL);
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   localparam logic [0:0] S_DIRECT = 1'b0;
   localparam logic [0:0] S_SCAN   = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [SW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  out_q, out_d;
   logic [SW-1:0] out_sel_q, out_sel_d;
   logic          out_valid_q, out_valid_d;

   logic [SW-1:0] next_ptr;
   logic          any_unmasked;
   logic          sel_ok;
   logic          scan_req;

   function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus_v, input logic [SW-1:0] idx);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) begin
         if (idx == SW'(k)) r = bus_v[k*W +: W];
      end
      return r;
   endfunction

   // Only a non-power-of-two N has select codes that do not name a channel.
   if (N == (1 << SW)) begin : g_sel_full
      assign sel_ok = 1'b1;
   end else begin : g_sel_part
      assign sel_ok = (bus.sel < SW'(N));
   end

   assign scan_req = (mode_e'(bus.mode) == MODE_SCAN);

   rr_next #(.N(N), .SW(SW)) u_rr_next (
      .ptr          (ptr_q),
      .mask         (bus.mask),
      .next         (next_ptr),
      .any_unmasked (any_unmasked)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      if (bus.en) begin
         if (state_q == S_DIRECT) begin
            out_d       = sel_ok ? pick(bus.in_bus, bus.sel) : '0;
            out_sel_d   = bus.sel;
            out_valid_d = sel_ok;
            ptr_d       = sel_ok ? bus.sel : '0;
            cnt_d       = '0;
            if (scan_req) state_d = S_SCAN;
         end else begin
            out_d       = any_unmasked ? pick(bus.in_bus, ptr_q) : '0;
            out_sel_d   = ptr_q;
            out_valid_d = ~bus.mask[ptr_q];
            // Leaving scan overrides a coincident dwell expiry: the pointer reloads from sel.
            if (!scan_req) begin
               state_d = S_DIRECT;
               ptr_d   = sel_ok ? bus.sel : '0;
               cnt_d   = '0;
            end else if (bus.mask[ptr_q] || (cnt_q == CNT_LAST)) begin
               ptr_d = next_ptr;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_DIRECT;
         ptr_q       <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.out_valid = out_valid_q;
   assign dbg_state     = state_e'(state_q);

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: N=8/DWELL=3 and N=6/DWELL=1 instances on shared stimulus, checked by table, sequences and a model.
module tb_mux_scan_n;
   import mux_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_bus;
   logic [2:0]  sel;
   logic        mode;
   logic        en;
   logic [7:0]  mask;
   state_e      dbg_a, dbg_b;

   int n_cmp = 0;
   int n_bad = 0;

   mux_scan_n_if #(.N(8), .W(4)) bus_a ();
   mux_scan_n_if #(.N(6), .W(4)) bus_b ();

   assign bus_a.in_bus = in_bus;
   assign bus_a.sel    = sel;
   assign bus_a.mode   = mode;
   assign bus_a.en     = en;
   assign bus_a.mask   = mask;
   assign bus_b.in_bus = in_bus[23:0];
   assign bus_b.sel    = sel;
   assign bus_b.mode   = mode;
   assign bus_b.en     = en;
   assign bus_b.mask   = mask[5:0];

   mux_scan_n #(.N(8), .W(4), .DWELL(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .dbg_state(dbg_a)
   );
   mux_scan_n #(.N(6), .W(4), .DWELL(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .dbg_state(dbg_b)
   );

   // clock / reset
   always #5 clk = ~clk;

   // behavioural reference: which channel is on air and how many times it has been shown
   typedef struct {
      bit         scan;
      int         ptr;
      int         shown;
      logic [3:0] out;
      int         osel;
      bit         valid;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.scan = 0; r.ptr = 0; r.shown = 0; r.out = 4'h0; r.osel = 0; r.valid = 0;
      return r;
   endfunction

   function automatic int next_unmasked(int p, int n, logic [7:0] m);
      for (int d = 1; d <= n; d++) begin
         if (!m[(p + d) % n]) return (p + d) % n;
      end
      return p;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int n, int dwell, logic [31:0] inb,
                                     int s, bit md, bit e, logic [7:0] mk);
      mdl_t r;
      int   live;
      r = m;
      if (!e) return m;
      live = 0;
      for (int i = 0; i < n; i++) if (!mk[i]) live++;
      if (!m.scan) begin
         r.osel  = s;
         r.valid = (s < n);
         r.out   = (s < n) ? inb[s*4 +: 4] : 4'h0;
         r.ptr   = (s < n) ? s : 0;
         r.shown = 0;
         r.scan  = md;
      end else begin
         r.osel  = m.ptr;
         r.valid = !mk[m.ptr];
         r.out   = (live > 0) ? inb[m.ptr*4 +: 4] : 4'h0;
         if (!md) begin
            r.scan  = 0;
            r.ptr   = (s < n) ? s : 0;
            r.shown = 0;
         end else if (mk[m.ptr] || (m.shown + 1 == dwell)) begin
            r.ptr   = next_unmasked(m.ptr, n, mk);
            r.shown = 0;
         end else begin
            r.shown = m.shown + 1;
         end
      end
      return r;
   endfunction

   // scoreboard helpers
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_a(input string nm, input int osel, input int out, input bit v);
      chk({nm, "_a_sel"}, 32'(bus_a.out_sel), osel);
      chk({nm, "_a_out"}, 32'(bus_a.out), out);
      chk({nm, "_a_valid"}, 32'(bus_a.out_valid), 32'(v));
   endtask

   task automatic chk_model(input string nm);
      chk({nm, "_a_out"},   32'(bus_a.out),       32'(ma.out));
      chk({nm, "_a_sel"},   32'(bus_a.out_sel),   ma.osel);
      chk({nm, "_a_valid"}, 32'(bus_a.out_valid), 32'(ma.valid));
      chk({nm, "_a_state"}, 32'(dbg_a),           32'(ma.scan));
      chk({nm, "_b_out"},   32'(bus_b.out),       32'(mb.out));
      chk({nm, "_b_sel"},   32'(bus_b.out_sel),   mb.osel);
      chk({nm, "_b_valid"}, 32'(bus_b.out_valid), 32'(mb.valid));
      chk({nm, "_b_state"}, 32'(dbg_b),           32'(mb.scan));
   endtask

   // driver: advance models with the inputs about to be sampled, then step one clock
   task automatic tick();
      if (rst_n) begin
         ma = mdl_step(ma, 8, 3, in_bus, int'(sel), mode, en, mask);
         mb = mdl_step(mb, 6, 1, in_bus, int'(sel), mode, en, mask);
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0] sel;
      logic [3:0] exp_a;
      logic       va;
      logic [3:0] exp_b;
      logic       vb;
   } vec_t;

   vec_t vt [8];
   int   exp_b4 [4];
   int   exp_a4 [4];
   int   exp_mk [5];
   bit   exp_mv [5];

   initial begin
      vt[0] = '{3'd0, 4'h0, 1'b1, 4'h0, 1'b1};
      vt[1] = '{3'd1, 4'h1, 1'b1, 4'h1, 1'b1};
      vt[2] = '{3'd2, 4'h2, 1'b1, 4'h2, 1'b1};
      vt[3] = '{3'd3, 4'h3, 1'b1, 4'h3, 1'b1};
      vt[4] = '{3'd4, 4'h4, 1'b1, 4'h4, 1'b1};
      vt[5] = '{3'd5, 4'h5, 1'b1, 4'h5, 1'b1};
      vt[6] = '{3'd6, 4'h6, 1'b1, 4'h0, 1'b0};
      vt[7] = '{3'd7, 4'h7, 1'b1, 4'h0, 1'b0};
      exp_b4 = '{0, 2, 4, 0};
      exp_a4 = '{0, 0, 0, 2};
      exp_mk = '{2, 4, 4, 4, 6};
      exp_mv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      in_bus = 32'h7654_3210; sel = 3'd0; mode = 1'b0; en = 1'b1; mask = 8'h00;
      ma = mdl_reset(); mb = mdl_reset();

      // reset values appear before any clock edge
      #1;
      chk_a("reset", 0, 0, 1'b0);
      chk("reset_a_state", 32'(dbg_a), 32'(ST_DIRECT));
      tick(); tick();
      rst_n = 1'b1;

      in_bus[15:12] = 4'hA; sel = 3'd3;
      tick();
      chk_a("post_reset", 3, 4'hA, 1'b1);
      in_bus = 32'h7654_3210;

      // direct sweep table
      for (int i = 0; i < 8; i++) begin
         sel = vt[i].sel;
         tick();
         chk_a($sformatf("direct%0d", i), int'(vt[i].sel), int'(vt[i].exp_a), vt[i].va);
         chk($sformatf("direct%0d_b_out", i), 32'(bus_b.out), 32'(vt[i].exp_b));
         chk($sformatf("direct%0d_b_valid", i), 32'(bus_b.out_valid), 32'(vt[i].vb));
         chk($sformatf("direct%0d_b_sel", i), 32'(bus_b.out_sel), 32'(vt[i].sel));
      end

      // scan with dwell 3 from sel=5, wrapping past 7
      sel = 3'd5; mode = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) begin
         tick();
         chk_a($sformatf("dwell%0d", i), (5 + i / 3) % 8, (5 + i / 3) % 8, 1'b1);
      end

      // mode drop on the dwell-expiry edge, then re-entry reloads from sel
      tick(); tick();
      mode = 1'b0; sel = 3'd2;
      tick(); tick();
      chk_a("race", 2, 2, 1'b1);
      chk("race_a_state", 32'(dbg_a), 32'(ST_DIRECT));
      sel = 3'd4; mode = 1'b1;
      tick(); tick();
      chk_a("reload", 4, 4, 1'b1);

      // masked scan: B (dwell 1) skips odd channels, A holds each for three cycles
      mode = 1'b0; sel = 3'd0;
      tick(); tick();
      mask = 8'hAA; mode = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("mask%0d_b_sel", i), 32'(bus_b.out_sel), exp_b4[i]);
         chk($sformatf("mask%0d_b_valid", i), 32'(bus_b.out_valid), 1);
         chk($sformatf("mask%0d_a_sel", i), 32'(bus_a.out_sel), exp_a4[i]);
      end

      // mask the channel currently on air mid-dwell
      mask = 8'hAE;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("midmask%0d_a_sel", i), 32'(bus_a.out_sel), exp_mk[i]);
         chk($sformatf("midmask%0d_a_valid", i), 32'(bus_a.out_valid), 32'(exp_mv[i]));
      end

      // everything masked: pointer frozen, output blanked
      mask = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_a($sformatf("allmask%0d", i), 6, 0, 1'b0);
      end

      // enable low for four cycles mid-dwell; mode and sel must be ignored
      mask = 8'h00;
      tick();
      chk_a("pre_freeze", 6, 6, 1'b1);
      en = 1'b0; mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_bus = $urandom; sel = 3'($urandom_range(0, 7));
         tick();
         chk_a($sformatf("freeze%0d", i), 6, 6, 1'b1);
      end
      en = 1'b1; mode = 1'b1; in_bus = 32'h7654_3210;
      tick(); chk_a("resume0", 6, 6, 1'b1);
      tick(); chk_a("resume1", 6, 6, 1'b1);
      tick(); chk_a("resume2", 7, 7, 1'b1);

      // asynchronous reset mid-dwell
      rst_n = 1'b0;
      ma = mdl_reset(); mb = mdl_reset();
      #2;
      chk_a("async_rst", 0, 0, 1'b0);
      chk("async_rst_a_state", 32'(dbg_a), 32'(ST_DIRECT));
      mode = 1'b0; sel = 3'd1;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk_a("after_rst", 1, 1, 1'b1);

      // randomized run against the model, with occasional reset pulses
      for (int i = 0; i < 1500; i++) begin
         in_bus = $urandom;
         sel    = 3'($urandom_range(0, 7));
         en     = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
               0:       mask = 8'h00;
               1:       mask = 8'hFF;
               default: mask = 8'($urandom);
            endcase
         end
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            ma = mdl_reset(); mb = mdl_reset();
            #2;
            chk_model("rand_rst");
            tick();
            rst_n = 1'b1;
         end
         tick();
         chk_model($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised, registered N-to-1 multiplexer with a selectable automatic channel-scan mode. It generalises the team's fixed 8:1 single-bit multiplexers to N channels of W bits. In direct mode, the output follows an external select. In scan mode, an internal pointer walks all unmasked channels with a programmable dwell time. The block sits between multi-channel sources (sensor/ADC lanes, status lines) and a single downstream consumer.

## Interface
- N, 8, channel count (2..64)
- W, 1, bits per channel
- DWELL, 1, cycles spent on each channel in scan mode (≥1)
- SW, $clog2(N), select width (derived, not overridable)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_bus  in  N*W  channel k occupies bits [k*W +: W]
- sel  in  SW  direct-mode select
- mode  in  1  0 = DIRECT, 1 = SCAN
- en  in  1  clock enable; 0 freezes all state and outputs
- mask  in  N  1 = channel excluded from scan (ignored in DIRECT)
- out  out  W  registered selected data
- out_sel  out  SW  channel index that produced `out`
- out_valid  out  1  `out` holds a legal, unmasked channel

## Operation
- FSM states: S_DIRECT and S_SCAN. The FSM samples `mode` on every enabled edge.
  - S_DIRECT→S_SCAN when mode=1.
  - S_SCAN→S_DIRECT when mode=0.
- S_DIRECT:
  - Update: out←in[sel], out_sel←sel, out_valid←1.
  - If sel ≥ N: out←0, out_valid←0, out_sel←sel.
- Entering S_SCAN:
  - ptr←sel if sel<N, else 0.
  - dwell counter←0.
  - The first scan output appears on the following cycle.
- S_SCAN, each enabled cycle:
  - Output update: out←in[ptr], out_sel←ptr, out_valid←!mask[ptr].
  - If mask[ptr]=1: ptr←next unmasked channel immediately; cnt←0.
  - Else if cnt=DWELL-1: ptr←next unmasked channel; cnt←0.
  - Otherwise: cnt←cnt+1.
- Next-unmasked search:
  - Circular search from ptr+1, wrapping N-1→0.
  - If ptr is the only unmasked channel, ptr stays.
  - If all channels are masked, ptr holds, out_valid←0, and out←0.
- mask changes take effect on the next enabled edge. No dwell is carried over to a newly selected channel.
- en=0: ptr, cnt, FSM state and all outputs hold. `mode` and `sel` are not sampled.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - out=0, out_sel=0, out_valid=0.
  - state=S_DIRECT, ptr=0, cnt=0.
- Latency: 1 cycle from in_bus/sel change to `out`. Outputs are registered, with no combinational path from inputs to outputs.
- Scan period: each unmasked channel is presented for exactly DWELL consecutive enabled cycles.
- Full sweep: (#unmasked)×DWELL enabled cycles.
- Boundary conditions:
  - Wrap-around: ptr N-1 → lowest unmasked index.
  - mode toggled on the same edge that dwell expires: the mode change wins and ptr reloads from sel.
  - rst_n asserted mid-dwell: all state clears. After release, the block resumes in S_DIRECT.
  - Reset deassertion is synchronised externally; no internal synchroniser.
  - N not a power of two: unused sel codes follow the sel ≥ N rule.

## Structure
- Shared package `mux_pkg`:
  - mode enum {MODE_DIRECT, MODE_SCAN}.
  - FSM state enum.
  - clog2 helper for SW.
- Sub-module `rr_next`: combinational circular next-unmasked finder.
  - Inputs: ptr, mask.
  - Outputs: next index, any_unmasked flag.
  - Reusable by future arbiters.
- Top level holds the FSM, dwell counter, ptr and output registers.

## Test plan
- Reset: N=8, W=4. Drive rst_n low mid-scan → out=0, out_sel=0, out_valid=0 with no clock edge. After release, DIRECT mode with sel=3, in3=0xA → out=0xA one cycle later.
- Direct sweep: step sel through 0..7 with in_k=k → out=k, out_valid=1, each one cycle after sel. With N=6, sel=7 → out=0, out_valid=0.
- Scan with dwell: N=8, DWELL=3, mask=0, sel=5 at entry → out_sel sequence 5,5,5,6,6,6,7,7,7,0,… (wrap verified).
- Masking: DWELL=1, mask=0b1010_1010 → out_sel cycles 0,2,4,6,0. Masking the current ptr mid-dwell → out_valid=0 for one cycle, then the next unmasked channel. mask=0xFF → out_valid=0 and ptr frozen.
- Enable and mode race: en=0 for 4 cycles during scan → outputs and ptr frozen, dwell resumes with no lost count. mode=0 asserted on a dwell-expiry edge → DIRECT output from sel on the next cycle.
